// File: rtl/star_power_ctrl.sv
// Star collection counter and star-power (invincibility) timer with blink flag.
// Build option: define STAR_POWER_BLINK_EN to enable the BLINK state and blink toggling.
module star_power_ctrl #(
   parameter int unsigned N_STARS      = 4,
   parameter int unsigned POWER_FRAMES = 600,
   parameter int unsigned BLINK_FRAMES = 120,
   parameter int unsigned BLINK_HALF   = 8
) (
   input  logic               sys_clk,
   input  logic               RST_N,
   input  logic [N_STARS-1:0] touch_star,
   input  logic               frame_tick,
   input  logic               level_clr,
   output logic [7:0]         star_count,
   output logic               collect_pulse,
   output logic               power_on,
   output logic               blink,
   output logic [9:0]         power_left
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned LEFT_W = 10;
   localparam int unsigned PH_W   = $clog2(BLINK_HALF);

   // Reject illegal configurations at elaboration.
   if (N_STARS < 1 || N_STARS > 8 || POWER_FRAMES < 1 || POWER_FRAMES > 1023 ||
       BLINK_FRAMES >= POWER_FRAMES || BLINK_HALF < 2 || BLINK_HALF > 32 ||
       (BLINK_HALF & (BLINK_HALF - 1)) != 0) begin : g_bad_cfg
      $error("star_power_ctrl: illegal parameter set");
   end

`ifdef STAR_POWER_BLINK_EN
   typedef enum logic [1:0] {S_IDLE, S_POWERED, S_BLINK} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_POWERED} state_t;
`endif

   state_t              state_q, state_d;
   logic [N_STARS-1:0]  touch_q;
   logic [N_STARS-1:0]  new_touch;
   logic [CNT_W-1:0]    n_new;
   logic                collect;
   logic [8:0]          count_sum;
   logic [7:0]          count_d;
   logic [LEFT_W-1:0]   left_d, left_dec;
   logic                on_d;

   // Rising-edge detect and popcount of newly touched stars.
   always_comb begin
      new_touch = touch_star & ~touch_q;
      n_new     = '0;
      for (int i = 0; i < int'(N_STARS); i++) begin
         n_new = n_new + CNT_W'(new_touch[i]);
      end
   end

   assign collect   = (n_new != '0);
   assign count_sum = {1'b0, star_count} + 9'(n_new);
   assign left_dec  = power_left - LEFT_W'(1);

`ifdef STAR_POWER_BLINK_EN
   logic [PH_W-1:0] phase_q, phase_d;
   logic            blink_d;
`endif

   // Next-state, timer and flag logic; collect always beats a coincident tick.
   always_comb begin
      state_d = state_q;
      left_d  = power_left;
      count_d = count_sum[8] ? 8'hFF : count_sum[7:0];
`ifdef STAR_POWER_BLINK_EN
      phase_d = phase_q;
      blink_d = blink;
`endif
      case (state_q)
         S_IDLE: begin
            if (collect) begin
               state_d = S_POWERED;
               left_d  = LEFT_W'(POWER_FRAMES);
            end
         end
         S_POWERED: begin
            if (collect) begin
               left_d = LEFT_W'(POWER_FRAMES);
            end else if (frame_tick) begin
               left_d = left_dec;
               if (left_dec == '0) begin
                  state_d = S_IDLE;
`ifdef STAR_POWER_BLINK_EN
               end else if (left_dec <= LEFT_W'(BLINK_FRAMES)) begin
                  state_d = S_BLINK;
                  phase_d = '0;
`endif
               end
            end
         end
`ifdef STAR_POWER_BLINK_EN
         S_BLINK: begin
            if (collect) begin
               state_d = S_POWERED;
               left_d  = LEFT_W'(POWER_FRAMES);
               blink_d = 1'b0;
               phase_d = '0;
            end else if (frame_tick) begin
               left_d = left_dec;
               if (phase_q == PH_W'(BLINK_HALF - 1)) begin
                  phase_d = '0;
                  blink_d = ~blink;
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
               if (left_dec == '0) begin
                  state_d = S_IDLE;
                  blink_d = 1'b0;
                  phase_d = '0;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            left_d  = '0;
         end
      endcase
      on_d = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (!RST_N || level_clr) begin
         state_q       <= S_IDLE;
         touch_q       <= '0;
         star_count    <= '0;
         collect_pulse <= 1'b0;
         power_on      <= 1'b0;
         power_left    <= '0;
      end else begin
         state_q       <= state_d;
         touch_q       <= touch_star;
         star_count    <= count_d;
         collect_pulse <= collect;
         power_on      <= on_d;
         power_left    <= left_d;
      end
   end

`ifdef STAR_POWER_BLINK_EN
   always_ff @(posedge sys_clk) begin
      if (!RST_N || level_clr) begin
         phase_q <= '0;
         blink   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         blink   <= blink_d;
      end
   end
`else
   assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_star_power_ctrl.sv
// Directed self-checking bench for star_power_ctrl (vector table plus timer sequences).
module tb_star_power_ctrl;

   logic       sys_clk = 1'b0;
   logic       RST_N;
   logic [3:0] touch_star;
   logic       frame_tick;
   logic       level_clr;
   logic [7:0] star_count;
   logic       collect_pulse;
   logic       power_on;
   logic       blink;
   logic [9:0] power_left;

   int n_cmp = 0;
   int n_bad = 0;

   star_power_ctrl #(
      .N_STARS(4), .POWER_FRAMES(600), .BLINK_FRAMES(120), .BLINK_HALF(8)
   ) dut (
      .sys_clk      (sys_clk),
      .RST_N        (RST_N),
      .touch_star   (touch_star),
      .frame_tick   (frame_tick),
      .level_clr    (level_clr),
      .star_count   (star_count),
      .collect_pulse(collect_pulse),
      .power_on     (power_on),
      .blink        (blink),
      .power_left   (power_left)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [3:0] touch;
      logic       tick;
      int         cnt;
      logic       pulse;
      logic       on;
      int         left;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] t, input logic tk, input logic cl);
      touch_star = t;
      frame_tick = tk;
      level_clr  = cl;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_all(input string name, input int cnt, input logic pulse,
                          input logic on, input logic bl, input int left);
      chk({name, ".count"}, int'(star_count), cnt);
      chk({name, ".pulse"}, int'(collect_pulse), int'(pulse));
      chk({name, ".on"}, int'(power_on), int'(on));
      chk({name, ".blink"}, int'(blink), int'(bl));
      chk({name, ".left"}, int'(power_left), left);
   endtask

   function automatic logic exp_blink(input int j);
`ifdef STAR_POWER_BLINK_EN
      if (j > 480 && j < 600) return logic'(((j - 480) / 8) % 2);
`endif
      return 1'b0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[12];
      vecs[0]  = '{4'b0001, 1'b0, 1, 1'b1, 1'b1, 600};
      vecs[1]  = '{4'b0001, 1'b0, 1, 1'b0, 1'b1, 600};
      vecs[2]  = '{4'b0001, 1'b0, 1, 1'b0, 1'b1, 600};
      vecs[3]  = '{4'b0001, 1'b0, 1, 1'b0, 1'b1, 600};
      vecs[4]  = '{4'b0001, 1'b0, 1, 1'b0, 1'b1, 600};
      vecs[5]  = '{4'b0000, 1'b1, 1, 1'b0, 1'b1, 599};
      vecs[6]  = '{4'b0000, 1'b1, 1, 1'b0, 1'b1, 598};
      vecs[7]  = '{4'b1011, 1'b0, 4, 1'b1, 1'b1, 600};
      vecs[8]  = '{4'b1011, 1'b1, 4, 1'b0, 1'b1, 599};
      vecs[9]  = '{4'b1111, 1'b1, 5, 1'b1, 1'b1, 600};
      vecs[10] = '{4'b0000, 1'b0, 5, 1'b0, 1'b1, 600};
      vecs[11] = '{4'b0000, 1'b1, 5, 1'b0, 1'b1, 599};

      RST_N = 1'b0;
      touch_star = '0;
      frame_tick = 1'b0;
      level_clr  = 1'b0;
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 0);
      RST_N = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].touch, vecs[i].tick, 1'b0);
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pulse,
                 vecs[i].on, 1'b0, vecs[i].left);
      end

      // Full run-down from a fresh collect.
      step(4'b0001, 1'b0, 1'b0);
      chk_all("rundown.start", 6, 1'b1, 1'b1, 1'b0, 600);
      for (int j = 1; j <= 600; j++) begin
         step(4'b0000, 1'b1, 1'b0);
         chk($sformatf("rundown.left%0d", j), int'(power_left), 600 - j);
         chk($sformatf("rundown.on%0d", j), int'(power_on), (j < 600) ? 1 : 0);
         chk($sformatf("rundown.blink%0d", j), int'(blink), int'(exp_blink(j)));
      end
      step(4'b0000, 1'b1, 1'b0);
      chk_all("rundown.idle", 6, 1'b0, 1'b0, 1'b0, 0);

      // Collect coincident with a tick at power_left=50 reloads and drops the tick.
      step(4'b0001, 1'b0, 1'b0);
      for (int j = 1; j <= 550; j++) step(4'b0000, 1'b1, 1'b0);
      chk_all("reload.pre", 7, 1'b0, 1'b1, 1'b0, 50);
      step(4'b0010, 1'b1, 1'b0);
      chk_all("reload.hit", 8, 1'b1, 1'b1, 1'b0, 600);
      for (int j = 1; j <= 9; j++) begin
         step(4'b0000, 1'b1, 1'b0);
         chk($sformatf("reload.left%0d", j), int'(power_left), 600 - j);
         chk($sformatf("reload.blink%0d", j), int'(blink), 0);
      end

      // level_clr mid-power with a held touch.
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      chk_all("clr.collect", 9, 1'b1, 1'b1, 1'b0, 600);
      for (int j = 1; j <= 300; j++) step(4'b0001, 1'b1, 1'b0);
      chk_all("clr.pre", 9, 1'b0, 1'b1, 1'b0, 300);
      step(4'b0001, 1'b0, 1'b1);
      chk_all("clr.cleared", 0, 1'b0, 1'b0, 1'b0, 0);
      step(4'b0001, 1'b0, 1'b0);
      chk_all("clr.recount", 1, 1'b1, 1'b1, 1'b0, 600);

      // Saturation: build up to 254, then add 3 and 1 more.
      step(4'b0000, 1'b0, 1'b1);
      chk("sat.clear", int'(star_count), 0);
      for (int r = 0; r < 63; r++) begin
         step(4'b1111, 1'b0, 1'b0);
         step(4'b0000, 1'b0, 1'b0);
      end
      chk("sat.252", int'(star_count), 252);
      step(4'b0011, 1'b0, 1'b0);
      chk("sat.254", int'(star_count), 254);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b1011, 1'b0, 1'b0);
      chk("sat.255", int'(star_count), 255);
      chk("sat.pulse", int'(collect_pulse), 1);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      chk("sat.hold", int'(star_count), 255);
      chk("sat.pulse2", int'(collect_pulse), 1);

      // Reset while powered.
      RST_N = 1'b0;
      step(4'b0100, 1'b1, 1'b0);
      chk_all("rst.mid", 0, 1'b0, 1'b0, 1'b0, 0);
      RST_N = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
